// File: rtl/regfile4_rd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile4_rd                                                   |
// | Brief    : 4x4-bit register file with a handshaked, registered read port |
// | Options  : REGFILE4_RD_BYPASS_EN - forward wdata on same-address collide |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile4_rd (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [3:0] wdata,
  input  logic       rd_req,
  input  logic [1:0] rd_addr,
  output logic       rd_gnt,
  output logic       rd_valid,
  output logic [3:0] rd_data,
  output logic [3:0] rd_data_b,
  input  logic       rd_ready,
  output logic [3:0] rd_count
);

  localparam int unsigned c_nregs = 4;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_regs [c_nregs];
  logic [3:0] r_rd_data;
  logic [3:0] r_rd_count;
  logic       r_rd_valid;
  logic       w_collide;
  logic [3:0] w_rd_value;

`ifdef REGFILE4_RD_BYPASS_EN
  assign w_collide = we && (waddr == rd_addr);
`else
  assign w_collide = 1'b0;
`endif

  // Without forwarding the read sees the pre-write contents of the register.
  assign w_rd_value = w_collide ? wdata : r_regs[rd_addr];

  assign rd_gnt    = rst_n && rd_req && ((r_state == S_IDLE) || rd_ready);
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_data_b = ~r_rd_data;
  assign rd_count  = r_rd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_nregs; i++) begin
        r_regs[i] <= 4'h0;
      end
    end else if (we) begin
      r_regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 4'h0;
      r_rd_count <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rd_req) begin
            r_rd_data  <= w_rd_value;
            r_rd_valid <= 1'b1;
            r_state    <= S_VALID;
          end
        end
        S_VALID: begin
          if (rd_ready) begin
            r_rd_count <= r_rd_count + 4'd1;
            if (rd_req) begin
              r_rd_data <= w_rd_value;
            end else begin
              r_rd_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: begin
          r_rd_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile4_rd.sv
`default_nettype none
// Testbench for regfile4_rd: directed vector table, hand sequences and a
// randomized run checked against a transaction-level model.
module tb_regfile4_rd;

  logic       clk, rst_n, we, rd_req, rd_ready;
  logic [1:0] waddr, rd_addr;
  logic [3:0] wdata;
  logic       rd_gnt, rd_valid;
  logic [3:0] rd_data, rd_data_b, rd_count;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE4_RD_BYPASS_EN
  localparam logic c_bypass = 1'b1;
`else
  localparam logic c_bypass = 1'b0;
`endif
  localparam logic [3:0] c_coll = c_bypass ? 4'h9 : 4'h2;

  regfile4_rd dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_data_b(rd_data_b), .rd_ready(rd_ready),
    .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: register contents plus the one outstanding read result.
  logic [3:0] m_regs [4];
  logic       m_valid;
  logic [3:0] m_data;
  logic [3:0] m_count;
  logic       last_gnt;

  typedef struct {
    logic       we;   logic [1:0] wa; logic [3:0] wd;
    logic       req;  logic [1:0] ra; logic       rdy;
    logic       eg;   logic       ev; logic [3:0] ed; logic [3:0] ec;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(logic iwe, logic [1:0] iwa, logic [3:0] iwd,
                             logic ireq, logic [1:0] ira, logic irdy,
                             logic eg, logic ev, logic [3:0] ed, logic [3:0] ec);
    vec_t r;
    r.we = iwe; r.wa = iwa; r.wd = iwd; r.req = ireq; r.ra = ira; r.rdy = irdy;
    r.eg = eg; r.ev = ev; r.ed = ed; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    m_valid = 1'b0;
    m_data  = 4'h0;
    m_count = 4'h0;
  endtask

  // Called between edges: asserts reset, checks immediate effect, holds 2 cycles.
  task automatic do_reset(input string tag);
    rd_req = 1'b1;
    rst_n  = 1'b0;
    model_reset();
    #1;
    chk({tag, "_valid_now"}, {3'b0, rd_valid}, 4'h0);
    chk({tag, "_data_now"}, rd_data, 4'h0);
    chk({tag, "_count_now"}, rd_count, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_valid"}, {3'b0, rd_valid}, 4'h0);
    chk({tag, "_data"}, rd_data, 4'h0);
    chk({tag, "_data_b"}, rd_data_b, 4'hF);
    chk({tag, "_count"}, rd_count, 4'h0);
    chk({tag, "_gnt"}, {3'b0, rd_gnt}, 4'h0);
    rst_n  = 1'b1;
    rd_req = 1'b0;
  endtask

  // One clock cycle starting just after a rising edge.
  task automatic step(input logic iwe, input logic [1:0] iwa, input logic [3:0] iwd,
                      input logic ireq, input logic [1:0] ira, input logic irdy);
    logic eg;
    we = iwe; waddr = iwa; wdata = iwd; rd_req = ireq; rd_addr = ira; rd_ready = irdy;
    #2;
    eg = ireq && (!m_valid || irdy);
    last_gnt = rd_gnt;
    chk("gnt", {3'b0, rd_gnt}, {3'b0, eg});
    if (m_valid && irdy) m_count = m_count + 4'd1;
    if (eg) begin
      m_data  = (iwe && iwa == ira && c_bypass) ? iwd : m_regs[ira];
      m_valid = 1'b1;
    end else if (m_valid && irdy) begin
      m_valid = 1'b0;
    end
    if (iwe) m_regs[iwa] = iwd;
    @(posedge clk);
    #1;
    chk("valid", {3'b0, rd_valid}, {3'b0, m_valid});
    chk("data", rd_data, m_data);
    chk("data_b", rd_data_b, ~m_data);
    chk("count", rd_count, m_count);
  endtask

  initial begin
    logic [3:0] prev_cnt;
    logic       saw_wrap;
    logic       hold;
    rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    rd_req = 1'b0; rd_addr = '0; rd_ready = 1'b0;
    model_reset();
    #2;
    do_reset("rst");

    // One-hot writes and reads, backpressure, collision.
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(1'b1, 2'(i), 4'(1 << i), 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 1, 1, 4'h1, 4'd0));
    tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 1, 4'h2, 4'd1));
    tbl.push_back(v(0, 0, 0, 1, 2, 1, 1, 1, 4'h4, 4'd2));
    tbl.push_back(v(0, 0, 0, 1, 3, 1, 1, 1, 4'h8, 4'd3));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 4'h8, 4'd4));
    tbl.push_back(v(0, 0, 0, 1, 2, 0, 1, 1, 4'h4, 4'd4));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(1, 2, 4'hF, 1, 2, 0, 0, 1, 4'h4, 4'd4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 4'h4, 4'd5));
    tbl.push_back(v(0, 0, 0, 1, 2, 1, 1, 1, 4'hF, 4'd5));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 4'hF, 4'd6));
    tbl.push_back(v(1, 1, 4'h9, 1, 1, 1, 1, 1, c_coll, 4'd6));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, c_coll, 4'd7));
    tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 1, 4'h9, 4'd7));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 4'h9, 4'd8));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].req, tbl[i].ra, tbl[i].rdy);
      chk($sformatf("tbl%0d_gnt", i), {3'b0, last_gnt}, {3'b0, tbl[i].eg});
      chk($sformatf("tbl%0d_valid", i), {3'b0, rd_valid}, {3'b0, tbl[i].ev});
      chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].ed);
      chk($sformatf("tbl%0d_data_b", i), rd_data_b, ~tbl[i].ed);
      chk($sformatf("tbl%0d_count", i), rd_count, tbl[i].ec);
    end

    // Back-to-back reads from a fresh count: 17 cycles, then release.
    #2;
    do_reset("rst2");
    step(1, 0, 4'h3, 0, 0, 0);
    step(1, 1, 4'h5, 0, 0, 0);
    step(1, 2, 4'hA, 0, 0, 0);
    step(1, 3, 4'hC, 0, 0, 0);
    saw_wrap = 1'b0;
    for (int i = 0; i < 17; i++) begin
      prev_cnt = rd_count;
      step(0, 0, 0, 1, 2'(i), 1);
      if (prev_cnt == 4'd15 && rd_count == 4'd0) saw_wrap = 1'b1;
    end
    step(0, 0, 0, 0, 0, 1);
    chk("b2b_end_count", rd_count, 4'd1);
    chk("b2b_wrap_seen", {3'b0, saw_wrap}, 4'h1);

    // Reset while a read is pending, between edges.
    step(0, 0, 0, 1, 2, 0);
    chk("midrd_valid_before", {3'b0, rd_valid}, 4'h1);
    #2;
    do_reset("midrd");

    // Randomized traffic; a pending request stays asserted until granted.
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = hold ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom),
           r, 2'($urandom), 1'($urandom_range(0, 3) != 0));
      hold = r && !last_gnt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
